// File: rtl/lsu_mem_port.sv
// Load/store unit port to a single-cycle data RAM: latency is 2 cycles (aligned) or 1 cycle (misaligned fault).
// Backpressure: one request in flight; req_ready is low until the response is taken with resp_ready.
module lsu_mem_port #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [1:0]        resp_exc,
  output logic [ADDR_W-1:0] resp_badvaddr,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [3:0]        ram_sel,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  state_t            state;
  logic              rdy_q;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_ext;

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
    case (op)
      OP_LH, OP_LHU, OP_SH: return off[0];
      OP_LW, OP_SW:         return off != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_sel(input logic [2:0] op, input logic [1:0] off);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 4'b0001 << off;
      OP_LH, OP_LHU, OP_SH: return off[1] ? 4'b1100 : 4'b0011;
      default:              return 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] lane_data(input logic [2:0] op, input logic [DATA_W-1:0] wd);
    case (op)
      OP_SB:   return {4{wd[7:0]}};
      OP_SH:   return {2{wd[15:0]}};
      OP_SW:   return wd;
      default: return '0;
    endcase
  endfunction

  assign req_ready = rdy_q;
  assign ram_raddr = addr_q;
  assign ram_waddr = addr_q;

  // Lane extraction from the RAM word that is valid during ACCESS.
  always_comb begin
    ld_byte = 8'h00;
    ld_half = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (addr_q[1:0])
      2'd0:    ld_byte = ram_rdata[7:0];
      2'd1:    ld_byte = ram_rdata[15:8];
      2'd2:    ld_byte = ram_rdata[23:16];
      default: ld_byte = ram_rdata[31:24];
    endcase
    case (op_q)
      OP_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_ext = {24'h0, ld_byte};
      OP_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_ext = {16'h0, ld_half};
      OP_LW:   ld_ext = ram_rdata;
      default: ld_ext = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= S_IDLE;
      rdy_q         <= 1'b0;
      op_q          <= 3'd0;
      addr_q        <= '0;
      ram_ce        <= 1'b0;
      ram_we        <= 1'b0;
      ram_sel       <= 4'b0000;
      ram_wdata     <= '0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_exc      <= 2'b00;
      resp_badvaddr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && rdy_q) begin
            op_q   <= req_op;
            addr_q <= req_addr;
            rdy_q  <= 1'b0;
            if (misaligned(req_op, req_addr[1:0])) begin
              // Fault: skip the RAM and report straight away.
              state         <= S_RESP;
              resp_valid    <= 1'b1;
              resp_rdata    <= '0;
              resp_exc      <= is_store(req_op) ? 2'b10 : 2'b01;
              resp_badvaddr <= req_addr;
            end else begin
              state     <= S_ACCESS;
              ram_ce    <= 1'b1;
              ram_we    <= is_store(req_op);
              ram_sel   <= lane_sel(req_op, req_addr[1:0]);
              ram_wdata <= lane_data(req_op, req_wdata);
            end
          end else begin
            rdy_q <= 1'b1;
          end
        end
        S_ACCESS: begin
          state         <= S_RESP;
          ram_ce        <= 1'b0;
          ram_we        <= 1'b0;
          ram_sel       <= 4'b0000;
          resp_valid    <= 1'b1;
          resp_rdata    <= is_store(op_q) ? '0 : ld_ext;
          resp_exc      <= 2'b00;
          resp_badvaddr <= '0;
        end
        S_RESP: begin
          if (resp_ready) begin
            state         <= S_IDLE;
            rdy_q         <= 1'b1;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_exc      <= 2'b00;
            resp_badvaddr <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          rdy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a byte-lane RAM model behind the port.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_exc;
  logic [31:0] resp_badvaddr;
  logic        ram_ce;
  logic        ram_we;
  logic [31:0] ram_raddr;
  logic [31:0] ram_waddr;
  logic [3:0]  ram_sel;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:255];

  logic        o_ce, o_we, ce_ever;
  logic [3:0]  o_sel;
  logic [31:0] o_wd, o_raddr, o_rdata, o_bad;
  logic [1:0]  o_exc;
  int          o_lat;

  always #5 clk = ~clk;

  lsu_mem_port #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_exc(resp_exc), .resp_badvaddr(resp_badvaddr),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_raddr(ram_raddr), .ram_waddr(ram_waddr),
    .ram_sel(ram_sel), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  assign ram_rdata = mem[ram_raddr[9:2]];

  always @(posedge clk) begin
    if (ram_ce && ram_we) begin
      for (int i = 0; i < 4; i++)
        if (ram_sel[i]) mem[ram_waddr[9:2]][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request with resp_ready=1 and records what the port did.
  task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    int w;
    w = 0;
    while (!req_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("req_ready_before_issue", {31'h0, req_ready}, 32'h1);
    req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    o_ce = ram_ce; o_we = ram_we; o_sel = ram_sel; o_wd = ram_wdata; o_raddr = ram_raddr;
    ce_ever = ram_ce;
    o_lat = 1;
    while (!resp_valid && o_lat < 10) begin
      @(posedge clk); #1;
      o_lat++;
      ce_ever = ce_ever | ram_ce;
    end
    o_rdata = resp_rdata; o_exc = resp_exc; o_bad = resp_badvaddr;
    @(posedge clk); #1;
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0;
    req_wdata = 32'h0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_ram_ce", {31'h0, ram_ce}, 32'h0);
    chk("rst_ram_sel", {28'h0, ram_sel}, 32'h0);
    chk("rst_ram_raddr", ram_raddr, 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_badvaddr", resp_badvaddr, 32'h0);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("req_ready_after_release", {31'h0, req_ready}, 32'h1);

    run_req(3'd7, 32'h100, 32'hDEADBEEF);
    chk("sw_ce", {31'h0, o_ce}, 32'h1);
    chk("sw_we", {31'h0, o_we}, 32'h1);
    chk("sw_sel", {28'h0, o_sel}, 32'hF);
    chk("sw_wdata", o_wd, 32'hDEADBEEF);
    chk("sw_raddr", o_raddr, 32'h100);
    chk("sw_lat", o_lat, 32'd2);
    chk("sw_exc", {30'h0, o_exc}, 32'h0);
    chk("sw_rdata", o_rdata, 32'h0);

    run_req(3'd0, 32'h103, 32'h0);
    chk("lb_sel", {28'h0, o_sel}, 32'h8);
    chk("lb_we", {31'h0, o_we}, 32'h0);
    chk("lb_rdata", o_rdata, 32'hFFFFFFDE);
    run_req(3'd1, 32'h103, 32'h0);
    chk("lbu_rdata", o_rdata, 32'h000000DE);
    run_req(3'd2, 32'h102, 32'h0);
    chk("lh_sel", {28'h0, o_sel}, 32'hC);
    chk("lh_rdata", o_rdata, 32'hFFFFDEAD);
    run_req(3'd3, 32'h100, 32'h0);
    chk("lhu_sel", {28'h0, o_sel}, 32'h3);
    chk("lhu_rdata", o_rdata, 32'h0000BEEF);

    run_req(3'd5, 32'h101, 32'h12);
    chk("sb_sel", {28'h0, o_sel}, 32'h2);
    chk("sb_wdata", o_wd, 32'h12121212);
    run_req(3'd4, 32'h100, 32'h0);
    chk("lw_rdata", o_rdata, 32'hDEAD12EF);
    chk("lw_lat", o_lat, 32'd2);

    run_req(3'd4, 32'h102, 32'h0);
    chk("lw_mis_lat", o_lat, 32'd1);
    chk("lw_mis_exc", {30'h0, o_exc}, 32'h1);
    chk("lw_mis_bad", o_bad, 32'h102);
    chk("lw_mis_ce", {31'h0, ce_ever}, 32'h0);
    chk("lw_mis_rdata", o_rdata, 32'h0);
    run_req(3'd6, 32'h203, 32'h5555);
    chk("sh_mis_exc", {30'h0, o_exc}, 32'h2);
    chk("sh_mis_bad", o_bad, 32'h203);
    chk("sh_mis_ce", {31'h0, ce_ever}, 32'h0);

    // Response stall with a competing request held on the input.
    resp_ready = 1'b0;
    req_op = 3'd4; req_addr = 32'h100; req_wdata = 32'h0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_op = 3'd5; req_addr = 32'h103; req_wdata = 32'hAA;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_resp_valid", {31'h0, resp_valid}, 32'h1);
      chk("stall_rdata", resp_rdata, 32'hDEAD12EF);
      chk("stall_exc", {30'h0, resp_exc}, 32'h0);
      chk("stall_req_ready", {31'h0, req_ready}, 32'h0);
      chk("stall_ce", {31'h0, ram_ce}, 32'h0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_valid", {31'h0, resp_valid}, 32'h0);
    chk("stall_release_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    chk("stall_no_extra_resp", {31'h0, resp_valid}, 32'h0);
    chk("stall_no_write", mem[8'h40], 32'hDEAD12EF);

    // Reset landing in the middle of an ACCESS cycle.
    req_op = 3'd7; req_addr = 32'h100; req_wdata = 32'h0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstacc_ce_before", {31'h0, ram_ce}, 32'h1);
    resetn = 1'b0;
    #1;
    chk("rstacc_ce_drop", {31'h0, ram_ce}, 32'h0);
    chk("rstacc_we_drop", {31'h0, ram_we}, 32'h0);
    @(posedge clk); #1;
    chk("rstacc_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rstacc_req_ready", {31'h0, req_ready}, 32'h0);
    chk("rstacc_raddr", ram_raddr, 32'h0);
    chk("rstacc_wdata", ram_wdata, 32'h0);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("rstacc_no_stale_resp", {31'h0, resp_valid}, 32'h0);
    run_req(3'd4, 32'h100, 32'h0);
    chk("rstacc_lw_rdata", o_rdata, 32'hDEAD12EF);
    chk("rstacc_lw_lat", o_lat, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the byte-address width of requests and RAM address ports.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the data width; only 32 is supported.
REQ-003 The block SHALL have port clk  input  1  system clock, rising-edge.
REQ-004 The block SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid  input  1  access request present.
REQ-006 The block SHALL have port req_ready  output  1  block can accept a request.
REQ-007 The block SHALL have port req_op  input  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW.
REQ-008 The block SHALL have port req_addr  input  ADDR_W  byte address.
REQ-009 The block SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 The block SHALL have port resp_valid  output  1  response present.
REQ-011 The block SHALL have port resp_ready  input  1  consumer accepts the response.
REQ-012 The block SHALL have port resp_rdata  output  32  extended load data; 0 for stores and exceptions.
REQ-013 The block SHALL have port resp_exc  output  2  00 none, 01 load misaligned, 10 store misaligned.
REQ-014 The block SHALL have port resp_badvaddr  output  ADDR_W  faulting address; 0 when resp_exc=00.
REQ-015 The block SHALL have ports ram_ce, ram_we (output 1 each), ram_raddr, ram_waddr (output ADDR_W each), ram_sel (output 4), ram_wdata (output 32) and ram_rdata (input 32), driving the downstream data RAM.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; op, addr and wdata are registered at that edge.
REQ-018 Misalignment SHALL be defined as: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=00.
REQ-019 An aligned request SHALL move IDLE->ACCESS; a misaligned request SHALL move IDLE->RESP with no RAM access.
REQ-020 In ACCESS (exactly one cycle), ram_ce SHALL be 1 and ram_we SHALL be 1 for stores and 0 for loads; ACCESS->RESP unconditionally.
REQ-021 ram_raddr and ram_waddr SHALL both carry the registered address in every state, because the RAM selects its address from raddr whenever ce=1.
REQ-022 Outside ACCESS, ram_ce, ram_we and ram_sel SHALL all be 0.
REQ-023 ram_sel SHALL follow little-endian lanes with off=addr[1:0]: byte ops 1<<off; halfword ops 0011 for off=0 and 1100 for off=2; word ops 1111.
REQ-024 ram_wdata SHALL be {4{wdata[7:0]}} for SB, {2{wdata[15:0]}} for SH and wdata for SW.
REQ-025 Load data SHALL be captured from ram_rdata at the rising edge ending ACCESS: byte = rdata[8*off+7:8*off], half = rdata[16*off[1]+15:16*off[1]].
REQ-026 LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend, and LW SHALL pass the word unchanged.
REQ-027 In RESP, resp_valid SHALL be 1 and resp_rdata, resp_exc and resp_badvaddr SHALL be held stable until resp_ready=1, then the FSM SHALL go RESP->IDLE.
REQ-028 Latency from accept to resp_valid SHALL be 2 cycles for aligned requests and 1 cycle for misaligned requests; a new request is accepted no earlier than the cycle after the response handshake.
REQ-029 req_valid asserted while not in IDLE SHALL be ignored, and the request SHALL NOT be accepted.

Reset
REQ-030 While resetn=0, state SHALL be IDLE and all registered outputs SHALL be 0 (ram_ce, ram_we, ram_sel, ram_raddr, ram_waddr, ram_wdata, resp_valid, resp_rdata, resp_exc, resp_badvaddr); req_ready SHALL be 0 while resetn=0 and 1 from the first cycle after release.
REQ-031 Reset asserted during ACCESS SHALL drop ram_ce/ram_we immediately (asynchronously); no RAM write SHALL occur at the following edge, and the pending response SHALL be discarded.

Verification
REQ-032 The bench SHALL cover: SW addr 0x100, wdata 0xDEADBEEF -> ACCESS cycle with ce=1, we=1, sel=1111, wdata=0xDEADBEEF; resp_exc=00, resp_rdata=0.
REQ-033 The bench SHALL cover: after the store above, LB 0x103 -> sel=1000, resp_rdata=0xFFFFFFDE; LBU 0x103 -> 0x000000DE; LH 0x102 -> 0xFFFFDEAD; LHU 0x100 -> 0x0000BEEF.
REQ-034 The bench SHALL cover: SB addr 0x101, wdata 0x12 -> sel=0010, ram_wdata=0x12121212; a subsequent LW 0x100 returns 0xDEAD12EF.
REQ-035 The bench SHALL cover: LW 0x102 -> resp_valid one cycle after accept, resp_exc=01, badvaddr=0x102, ram_ce never 1; SH 0x203 -> resp_exc=10, badvaddr=0x203.
REQ-036 The bench SHALL cover: resp_ready held 0 for 5 cycles -> resp_valid and data stable, req_ready=0, and a concurrent req_valid is not accepted.
REQ-037 The bench SHALL cover: resetn pulled low during ACCESS of SW 0x100 with 0x0 -> ram_ce drops at once, a later LW 0x100 still returns the prior value, and outputs read 0 during reset.
